// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the sweep sequencer and its counter.
package sweep_pkg;

   localparam int unsigned SWEEP_WIDTH    = 8;
   localparam int unsigned SWEEP_SWEEPS_W = 4;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StUp,
      StDown,
      StDone
   } sweep_state_t;

endpackage

// File: rtl/up_down_counter.sv
// Loadable up/down counter with synchronous active-low reset; load wins over count enable.
module up_down_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ud,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] cont
);

   logic [WIDTH-1:0] cont_q, cont_d;

   always_comb begin
      cont_d = cont_q;
      if (load) begin
         cont_d = d;
      end else if (en) begin
         cont_d = ud ? cont_q + 1'b1 : cont_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

   assign cont = cont_q;

endmodule

// File: rtl/sweep_controller.sv
// Start/abort/done sequencer sweeping the counter lo..hi..lo for n_sweeps sweeps.
// Build option: SWEEP_CONTINUOUS_EN makes n_sweeps == 0 sweep until aborted.
module sweep_controller
   import sweep_pkg::*;
#(
   parameter int unsigned WIDTH    = SWEEP_WIDTH,
   parameter int unsigned SWEEPS_W = SWEEP_SWEEPS_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [WIDTH-1:0]    lo,
   input  logic [WIDTH-1:0]    hi,
   input  logic [SWEEPS_W-1:0] n_sweeps,
   output logic [WIDTH-1:0]    cont,
   output logic                ud,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [SWEEPS_W-1:0] sweep_cnt
);

   sweep_state_t        state_q, state_d;
   logic [WIDTH-1:0]    lo_q, lo_d, hi_q, hi_d;
   logic [SWEEPS_W-1:0] n_q, n_d, sweep_cnt_q, sweep_cnt_d;
   logic                ud_q, ud_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic                cnt_en, cnt_load;
   logic [WIDTH-1:0]    hi_m1, lo_p1;
   logic [SWEEPS_W-1:0] sweep_nxt;
   logic                params_bad, last_sweep;

   assign hi_m1     = hi_q - 1'b1;
   assign lo_p1     = lo_q + 1'b1;
   assign sweep_nxt = sweep_cnt_q + 1'b1;

`ifdef SWEEP_CONTINUOUS_EN
   assign params_bad = (lo >= hi);
   // n_q == 0 never finishes, even when sweep_cnt wraps back to zero
   assign last_sweep = (n_q != '0) && (sweep_nxt == n_q);
`else
   assign params_bad = (lo >= hi) || (n_sweeps == '0);
   assign last_sweep = (sweep_nxt == n_q);
`endif

   always_comb begin
      state_d     = state_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      n_d         = n_q;
      sweep_cnt_d = sweep_cnt_q;
      ud_d        = ud_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cnt_en      = 1'b0;
      cnt_load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               lo_d        = lo;
               hi_d        = hi;
               n_d         = n_sweeps;
               sweep_cnt_d = '0;
               if (params_bad) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = StLoad;
                  busy_d  = 1'b1;
                  ud_d    = 1'b1;
               end
            end
         end
         StLoad: begin
            if (abort) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               cnt_load = 1'b1;
               state_d  = StUp;
            end
         end
         StUp: begin
            if (abort) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               cnt_en = 1'b1;
               if (cont == hi_m1) begin
                  state_d = StDown;
                  ud_d    = 1'b0;
               end
            end
         end
         StDown: begin
            if (abort) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               cnt_en = 1'b1;
               if (cont == lo_p1) begin
                  sweep_cnt_d = sweep_nxt;
                  if (last_sweep) begin
                     state_d = StDone;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StUp;
                     ud_d    = 1'b1;
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         lo_q        <= '0;
         hi_q        <= '0;
         n_q         <= '0;
         sweep_cnt_q <= '0;
         ud_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         n_q         <= n_d;
         sweep_cnt_q <= sweep_cnt_d;
         ud_q        <= ud_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // ud_q already reflects the direction of the current state
   up_down_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk  (clk),
      .rst  (rst),
      .en   (cnt_en),
      .ud   (ud_q),
      .load (cnt_load),
      .d    (lo_q),
      .cont (cont)
   );

   assign ud        = ud_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign sweep_cnt = sweep_cnt_q;

endmodule

// File: doc/sweep_controller.md
# sweep_controller

Self-contained sweep sequencer built around the team's 8-bit up/down counter. On a start command it loads a lower limit and counts up to an upper limit and back down, which makes one sweep, for a programmed number of sweeps. It then pulses `done`. It replaces hand-driven `ud`/`rst` sequencing and gives the rest of the design one start/abort/done handshake for the counter.

## Interface
Parameters:
- `WIDTH`, default 8: counter and limit width.
- `SWEEPS_W`, default 4: width of the sweep count and sweep counter.

Ports:
- `clk`  in  1: rising-edge clock; the only clock in the block.
- `rst`  in  1: reset; synchronous, active-low.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `abort`  in  1: stops any active sequence.
- `lo`  in  WIDTH: lower limit; latched on an accepted start.
- `hi`  in  WIDTH: upper limit; latched on an accepted start.
- `n_sweeps`  in  SWEEPS_W: number of full sweeps; latched on an accepted start.
- `cont`  out  WIDTH: current counter value.
- `ud`  out  1: current direction; 1 = up, 0 = down.
- `busy`  out  1: high in LOAD, UP and DOWN.
- `done`  out  1: one-cycle pulse at sequence end.
- `err`  out  1: pulses together with `done` when the parameters were invalid.
- `sweep_cnt`  out  SWEEPS_W: number of completed sweeps.

## Operation
- States: IDLE, LOAD, UP, DOWN, DONE.
- IDLE:
  - `start`=1 and `abort`=0: latch `lo`/`hi`/`n_sweeps` and clear `sweep_cnt`.
  - If `lo`>=`hi`, or `n_sweeps`==0 (see Configuration), go to DONE with the error flag set. Otherwise go to LOAD.
- LOAD: counter loads `lo`, `ud`=1, then go to UP.
- UP: `cont` increments every cycle. On the cycle where `cont`==`hi`-1 it still increments, and the state becomes DOWN. `hi` is therefore held for exactly one cycle.
- DOWN: `ud`=0 and `cont` decrements every cycle. On the cycle where `cont`==`lo`+1 it still decrements and `sweep_cnt` increments. Then:
  - new `sweep_cnt`==`n_sweeps`: go to DONE;
  - otherwise: go to UP with `ud`=1.
- DONE: `done`=1 for one cycle, plus `err`=1 if flagged, then go to IDLE. The counter holds its value.
- Arithmetic:
  - `cont` never wraps; the range is exactly `lo`..`hi`.
  - `hi`=2^WIDTH-1 and `lo`=0 are legal.
  - Limit comparisons are unsigned. `hi`-1 and `lo`+1 are computed in WIDTH bits; they are valid because `lo`<`hi`.
- `abort`=1 in LOAD, UP or DOWN:
  - next state is IDLE, with no `done` pulse;
  - `cont`, `ud` and `sweep_cnt` hold.
- `abort` in IDLE or DONE has no effect.
- `start` while not in IDLE is ignored. When `start` and `abort` are both high in IDLE, `abort` wins and the block stays in IDLE.
- Limit and count inputs are don't-care except on the cycle a start is accepted.

## Timing
- All outputs are registered. Reset values: state IDLE, `cont`=0, `ud`=1, `busy`=0, `done`=0, `err`=0, `sweep_cnt`=0.
- Reset overrides every state, including mid-sweep, and has priority over `start` and `abort` on the same edge.
- Start accepted at edge k: `busy`=1 from k. After edge k+1, `cont`=`lo`.
- Busy duration is 1 + 2·(`hi`-`lo`)·`n_sweeps` cycles. `done` is high in the cycle immediately after `busy` falls, and `cont`=`lo` at that point.
- Invalid parameters: `done`=`err`=1 in the cycle after the start edge; `busy` is never asserted.
- A new start can be accepted in the first IDLE cycle after DONE.

## Configuration
- `SWEEP_CONTINUOUS_EN` defined:
  - `n_sweeps`==0 means sweep indefinitely until `abort`;
  - `sweep_cnt` wraps modulo 2^SWEEPS_W;
  - DONE is never reached in this mode.
- `SWEEP_CONTINUOUS_EN` undefined: `n_sweeps`==0 is invalid, which gives the `err`/`done` pulse.

## Structure
- `sweep_pkg` holds the state enum typedef (`sweep_state_t`) and the `WIDTH`/`SWEEPS_W` default constants.
- Sub-module `up_down_counter`:
  - parameter `WIDTH`;
  - ports `clk`, `rst`, `en`, `ud`, `load`, `d`, `cont`;
  - same synchronous active-low reset;
  - `load` has priority over `en`.
- `sweep_controller` contains the FSM, the limit registers and `sweep_cnt`, and drives the counter's `en`/`ud`/`load`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles mid-UP (lo=5, hi=50) -> `cont`=0, `ud`=1, `busy`=0, `done`=0, state IDLE; a `start` in the same cycle is ignored.
- Basic: lo=10, hi=13, n=2 -> `cont` runs 10,11,12,13,12,11,10,11,12,13,12,11,10; `sweep_cnt` 1 then 2; `busy` for 13 cycles; then one `done` pulse with `err`=0.
- Full range: lo=0, hi=255, n=1 -> reaches 255 with no wrap and returns to 0; `busy` for 511 cycles.
- Invalid: lo=20, hi=20, n=1, and separately n=0 with the macro off -> `done`=`err`=1 the next cycle, `busy`=0, `cont` unchanged.
- Abort: lo=10, hi=20 with `abort` while DOWN at `cont`=15 -> IDLE next cycle, `cont` holds 15, no `done`; a following start with lo=1, hi=2, n=1 completes normally.
- Continuous (macro on): n=0, lo=0, hi=3 -> periodic 0..3..0 triangle; `sweep_cnt` wraps 15->0; stops only on `abort`.
